// File: rtl/memory_read_arbiter.sv
// Round-robin arbiter that funnels per-port instruction fetches onto one BRAM read port
// and broadcasts each returned word so every port waiting on that address completes together.
module memory_read_arbiter #(
  parameter int N_PORTS           = 4,
  parameter int MEMORY_ADDR_WIDTH = 10,
  parameter int MEMORY_WIDTH      = 32,
  parameter int MEM_LATENCY       = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [N_PORTS-1:0]                     req_valid_i,
  input  logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0]   req_addr_i,
  output logic [N_PORTS-1:0]                     req_ready_o,
  output logic [MEMORY_WIDTH-1:0]                rsp_data_o,
  output logic [MEMORY_ADDR_WIDTH-1:0]           broadcast_addr_o,
  output logic                                   broadcast_valid_o,
  output logic                                   mem_en_o,
  output logic [MEMORY_ADDR_WIDTH-1:0]           mem_addr_o,
  input  logic [MEMORY_WIDTH-1:0]                mem_rdata_i
);

  localparam int PW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int AW   = MEMORY_ADDR_WIDTH;
  localparam int LAST = MEM_LATENCY - 1;

  logic [PW-1:0]           rrPtr_q, rrPtr_d;
  logic [N_PORTS-1:0]      inflight_q, inflight_d;
  logic                    tagValid_q [MEM_LATENCY];
  logic [PW-1:0]           tagPort_q  [MEM_LATENCY];
  logic [AW-1:0]           tagAddr_q  [MEM_LATENCY];
  logic [MEMORY_WIDTH-1:0] rspData_q;
  logic [AW-1:0]           bcastAddr_q;

  logic [AW-1:0]      portAddr [N_PORTS];
  logic [N_PORTS-1:0] matchBcast;
  logic [N_PORTS-1:0] eligible;
  logic               respValid;
  logic [AW-1:0]      respAddr;
  logic               grantFound;
  logic [PW-1:0]      grantIdx;

  assign respValid = tagValid_q[LAST];
  assign respAddr  = tagAddr_q[LAST];

  // A port already being answered this cycle must not be reissued to the BRAM.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      portAddr[i]    = req_addr_i[i*AW +: AW];
      matchBcast[i]  = respValid && (portAddr[i] == respAddr);
      eligible[i]    = req_valid_i[i] & ~inflight_q[i] & ~matchBcast[i];
      req_ready_o[i] = req_valid_i[i] & matchBcast[i];
    end
  end

  always_comb begin
    int idx;
    grantFound = 1'b0;
    grantIdx   = '0;
    idx        = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = (int'(rrPtr_q) + k) % N_PORTS;
      if (!grantFound && eligible[idx]) begin
        grantFound = 1'b1;
        grantIdx   = PW'(idx);
      end
    end
  end

  assign mem_en_o   = grantFound;
  assign mem_addr_o = portAddr[grantIdx];

  // Set is applied after clear so a same-edge clear/set of one port leaves it in flight.
  always_comb begin
    rrPtr_d    = rrPtr_q;
    inflight_d = inflight_q;
    if (respValid) begin
      inflight_d[tagPort_q[LAST]] = 1'b0;
    end
    if (grantFound) begin
      inflight_d[grantIdx] = 1'b1;
      rrPtr_d = (grantIdx == PW'(N_PORTS - 1)) ? '0 : grantIdx + PW'(1);
    end
  end

  assign broadcast_valid_o = respValid;
  assign broadcast_addr_o  = respValid ? respAddr : bcastAddr_q;
  assign rsp_data_o        = respValid ? mem_rdata_i : rspData_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q     <= '0;
      inflight_q  <= '0;
      rspData_q   <= '0;
      bcastAddr_q <= '0;
      for (int s = 0; s < MEM_LATENCY; s++) begin
        tagValid_q[s] <= 1'b0;
        tagPort_q[s]  <= '0;
        tagAddr_q[s]  <= '0;
      end
    end else begin
      rrPtr_q       <= rrPtr_d;
      inflight_q    <= inflight_d;
      tagValid_q[0] <= grantFound;
      tagPort_q[0]  <= grantIdx;
      tagAddr_q[0]  <= mem_addr_o;
      for (int s = 1; s < MEM_LATENCY; s++) begin
        tagValid_q[s] <= tagValid_q[s-1];
        tagPort_q[s]  <= tagPort_q[s-1];
        tagAddr_q[s]  <= tagAddr_q[s-1];
      end
      if (respValid) begin
        rspData_q   <= mem_rdata_i;
        bcastAddr_q <= respAddr;
      end
    end
  end

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Directed bench for memory_read_arbiter: one instance with 1-cycle and one with 2-cycle
// BRAM latency, both driven from the same request bus, each with its own BRAM model.
module tb_memory_read_arbiter;

  localparam int NP = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [NP-1:0]   reqValid;
  logic [NP*AW-1:0] reqAddr;

  logic [NP-1:0] readyA, readyB;
  logic [DW-1:0] rspA, rspB, rdA, rdB1, rdB2;
  logic [AW-1:0] baddrA, baddrB, memAddrA, memAddrB;
  logic          bvalidA, bvalidB, memEnA, memEnB;

  int checkCount = 0;
  int errCount   = 0;

  memory_read_arbiter #(.N_PORTS(NP), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW), .MEM_LATENCY(1)) dutA (
    .clk(clk), .rst_n(rst_n), .req_valid_i(reqValid), .req_addr_i(reqAddr),
    .req_ready_o(readyA), .rsp_data_o(rspA), .broadcast_addr_o(baddrA),
    .broadcast_valid_o(bvalidA), .mem_en_o(memEnA), .mem_addr_o(memAddrA), .mem_rdata_i(rdA));

  memory_read_arbiter #(.N_PORTS(NP), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW), .MEM_LATENCY(2)) dutB (
    .clk(clk), .rst_n(rst_n), .req_valid_i(reqValid), .req_addr_i(reqAddr),
    .req_ready_o(readyB), .rsp_data_o(rspB), .broadcast_addr_o(baddrB),
    .broadcast_valid_o(bvalidB), .mem_en_o(memEnB), .mem_addr_o(memAddrB), .mem_rdata_i(rdB2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  // BRAM models: registered read, one and two stages deep.
  always @(posedge clk) begin
    if (memEnA) rdA <= memWord(memAddrA);
    if (memEnB) rdB1 <= memWord(memAddrB);
    rdB2 <= rdB1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic setAddr(input int port, input logic [AW-1:0] a);
    reqAddr[port*AW +: AW] = a;
  endtask

  task automatic applyReset();
    rst_n    = 1'b0;
    reqValid = '0;
    reqAddr  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [NP-1:0] expReady [5];
  logic [NP-1:0] validSeq [5];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rdA = '0; rdB1 = '0; rdB2 = '0;
    expReady = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    validSeq = '{4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    // Reset values and single request on port 1.
    applyReset();
    #1;
    checkOutput("rst_mem_en", memEnA, 0);
    checkOutput("rst_ready", readyA, 0);
    checkOutput("rst_bvalid", bvalidA, 0);
    checkOutput("rst_rsp", rspA, 0);
    checkOutput("rst_baddr", baddrA, 0);
    nextCycle(); reqValid = 4'b0010; setAddr(1, 10'h012); #1;
    checkOutput("t1_mem_en", memEnA, 1);
    checkOutput("t1_mem_addr", memAddrA, 10'h012);
    checkOutput("t1_ready_early", readyA, 0);
    nextCycle(); #1;
    checkOutput("t1_ready", readyA, 4'b0010);
    checkOutput("t1_rsp", rspA, memWord(10'h012));
    checkOutput("t1_baddr", baddrA, 10'h012);
    checkOutput("t1_bvalid", bvalidA, 1);
    checkOutput("t1_no_reissue", memEnA, 0);
    nextCycle(); reqValid = '0; #1;
    checkOutput("t1_idle_bvalid", bvalidA, 0);
    checkOutput("t1_idle_ready", readyA, 0);
    checkOutput("t1_hold_rsp", rspA, memWord(10'h012));
    checkOutput("t1_hold_baddr", baddrA, 10'h012);

    // Four ports with distinct addresses, round-robin order 0..3.
    applyReset();
    for (int p = 0; p < NP; p++) setAddr(p, AW'(10'h010 + p));
    for (int k = 0; k < 5; k++) begin
      nextCycle(); reqValid = validSeq[k]; #1;
      checkOutput($sformatf("rr_en_%0d", k), memEnA, (k < 4) ? 1 : 0);
      if (k < 4) checkOutput($sformatf("rr_addr_%0d", k), memAddrA, 10'h010 + k);
      checkOutput($sformatf("rr_ready_%0d", k), readyA, expReady[k]);
    end
    checkOutput("rr_rsp_last", rspA, memWord(10'h013));
    nextCycle(); reqValid = 4'b0101; setAddr(0, 10'h020); setAddr(2, 10'h022); #1;
    checkOutput("rr_wrap_addr", memAddrA, 10'h020);
    checkOutput("rr_wrap_ready", readyA, 0);

    // Two ports on the same address coalesce into one BRAM read.
    applyReset();
    nextCycle(); reqValid = 4'b0101; setAddr(0, 10'h040); setAddr(2, 10'h040); #1;
    checkOutput("co_en", memEnA, 1);
    checkOutput("co_addr", memAddrA, 10'h040);
    nextCycle(); #1;
    checkOutput("co_ready", readyA, 4'b0101);
    checkOutput("co_no_second_read", memEnA, 0);
    checkOutput("co_rsp", rspA, memWord(10'h040));
    nextCycle(); reqValid = '0; #1;
    checkOutput("co_after_en", memEnA, 0);

    // Latency 2: back-to-back fetches on port 3 are serialised by the in-flight bit.
    applyReset();
    nextCycle(); reqValid = 4'b1000; setAddr(3, 10'h100); #1;
    checkOutput("l2_en0", memEnB, 1);
    checkOutput("l2_addr0", memAddrB, 10'h100);
    nextCycle(); #1;
    checkOutput("l2_blocked", memEnB, 0);
    checkOutput("l2_ready_wait", readyB, 0);
    checkOutput("l2_bvalid_wait", bvalidB, 0);
    nextCycle(); #1;
    checkOutput("l2_ready0", readyB, 4'b1000);
    checkOutput("l2_rsp0", rspB, memWord(10'h100));
    checkOutput("l2_en_at_ready", memEnB, 0);
    nextCycle(); setAddr(3, 10'h101); #1;
    checkOutput("l2_en1", memEnB, 1);
    checkOutput("l2_addr1", memAddrB, 10'h101);
    checkOutput("l2_ready_gap", readyB, 0);
    nextCycle(); #1;
    checkOutput("l2_ready_wait1", readyB, 0);
    nextCycle(); #1;
    checkOutput("l2_ready1", readyB, 4'b1000);
    checkOutput("l2_rsp1", rspB, memWord(10'h101));
    nextCycle(); reqValid = '0;

    // Reset with two reads in flight discards them.
    applyReset();
    nextCycle(); reqValid = 4'b0011; setAddr(0, 10'h030); setAddr(1, 10'h031); #1;
    checkOutput("rf_addr0", memAddrB, 10'h030);
    nextCycle(); #1;
    checkOutput("rf_addr1", memAddrB, 10'h031);
    nextCycle(); rst_n = 1'b0; reqValid = '0; #1;
    checkOutput("rf_bvalid", bvalidB, 0);
    checkOutput("rf_ready", readyB, 0);
    checkOutput("rf_en", memEnB, 0);
    checkOutput("rf_rsp", rspB, 0);
    checkOutput("rf_baddr", baddrB, 0);
    nextCycle(); rst_n = 1'b1; #1;
    for (int k = 0; k < 2; k++) begin
      nextCycle(); #1;
      checkOutput($sformatf("rf_quiet_bvalid_%0d", k), bvalidB, 0);
    end
    nextCycle(); reqValid = 4'b0100; setAddr(2, 10'h033); #1;
    checkOutput("rf_new_en", memEnB, 1);
    checkOutput("rf_new_ready", readyB, 0);
    nextCycle(); #1;
    checkOutput("rf_new_wait", readyB, 0);
    nextCycle(); #1;
    checkOutput("rf_new_ready2", readyB, 4'b0100);
    checkOutput("rf_new_rsp", rspB, memWord(10'h033));
    nextCycle(); reqValid = '0;

    // Port 0 withdraws mid-read: response still broadcast, no ready, in-flight cleared.
    applyReset();
    nextCycle(); reqValid = 4'b0001; setAddr(0, 10'h050); #1;
    checkOutput("dv_en", memEnA, 1);
    nextCycle(); reqValid = '0; #1;
    checkOutput("dv_bvalid", bvalidA, 1);
    checkOutput("dv_ready", readyA, 0);
    checkOutput("dv_baddr", baddrA, 10'h050);
    nextCycle(); reqValid = 4'b0001; setAddr(0, 10'h051); #1;
    checkOutput("dv_regrant_en", memEnA, 1);
    checkOutput("dv_regrant_addr", memAddrA, 10'h051);
    nextCycle(); reqValid = '0;

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
